pcler8_seq_ctrl: RTL

- Sequencing controller for the 8-bit loadable up-counter datapath.
  - The datapath has load, count-enable, inhibit and carry-out cascade-reload behaviour.
- Adds the missing pieces:
  - the state register;
  - a configuration handshake;
  - a programmable prescaler;
  - a one-shot / auto-reload mode FSM.
- Sits between a CPU-side configuration port and timer/event consumers that need a terminal-count strobe.

---
 rtl/pcler8_pkg.sv | 28 ++
 rtl/pcler8_seq_ctrl_if.sv | 33 +++
 rtl/pcler8_next.sv | 30 +++
 rtl/pcler8_seq_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/pcler8_pkg.sv
// Shared types and constants for the 8-bit sequenced up-counter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcler8_pkg;

    // Counter width is fixed by the datapath; prescaler width sets the
    // storage layout of the latched configuration.
    localparam int CNT_W = 8;
    localparam int PRE_W = 4;

    // Terminal count: stepping from this value reloads and raises carry.
    localparam logic [CNT_W-1:0] TC_VAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] reload;
        logic             mode;      // 0 = one-shot, 1 = auto-reload
        logic [PRE_W-1:0] prescale;  // step every prescale+1 enabled cycles
    } cfg_t;

endpackage

// File: rtl/pcler8_seq_ctrl_if.sv
// Configuration handshake, run control and counter status bundle.
// Latency: n/a (wires only).
// Backpressure: cfg_valid is held by the master until it sees cfg_ready.
// Ports: master drives cfg_*, run_en, abort; slave (controller) drives
//        cfg_ready, cnt_out, tc_pulse, busy, done.
interface pcler8_seq_ctrl_if #(
    parameter int PRE_W = pcler8_pkg::PRE_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [7:0]       cfg_start;
    logic [7:0]       cfg_reload;
    logic             cfg_mode;
    logic [PRE_W-1:0] cfg_prescale;
    logic             run_en;
    logic             abort;
    logic [7:0]       cnt_out;
    logic             tc_pulse;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_start, cfg_reload, cfg_mode, cfg_prescale,
        output run_en, abort,
        input  cfg_ready, cnt_out, tc_pulse, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_reload, cfg_mode, cfg_prescale,
        input  run_en, abort,
        output cfg_ready, cnt_out, tc_pulse, busy, done
    );
endinterface

// File: rtl/pcler8_next.sv
// Next-count function of the loadable up-counter datapath (load > inhibit > count).
// Latency: combinational.
// Backpressure: none; i_inhibit freezes the count.
// Ports: i_cnt current value, i_din load value, i_reload wrap value,
//        i_load/i_cnt_en/i_inhibit controls; o_next_cnt, o_carry (wrap this cycle).
module pcler8_next
    import pcler8_pkg::*;
(
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_din,
    input  logic [CNT_W-1:0] i_reload,
    input  logic             i_load,
    input  logic             i_cnt_en,
    input  logic             i_inhibit,
    output logic [CNT_W-1:0] o_next_cnt,
    output logic             o_carry
);
    logic w_count;

    always_comb begin
        w_count    = i_cnt_en & ~i_inhibit;
        o_carry    = w_count & (i_cnt == TC_VAL);
        o_next_cnt = i_cnt;
        if (i_load) begin
            o_next_cnt = i_din;
        end else if (w_count) begin
            o_next_cnt = (i_cnt == TC_VAL) ? i_reload : i_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/pcler8_seq_ctrl.sv
// Sequencing controller: config handshake, prescaler and one-shot/auto-reload FSM.
// Latency: accept -> LOAD (1 cycle) -> RUN; tc_pulse is registered, coincident with cnt_out == reload.
// Backpressure: cfg_ready only in IDLE/DONE; run_en=0 freezes counter and prescaler.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the config
//        handshake, run_en/abort controls and cnt_out/tc_pulse/busy/done status.
module pcler8_seq_ctrl
    import pcler8_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PRE_W = pcler8_pkg::PRE_W
) (
    input  logic              clk,
    input  logic              rst,
    pcler8_seq_ctrl_if.slave  bus
);
    // The datapath is 8 bits and the config struct layout comes from the package.
    if (CNT_W != 8 || PRE_W != pcler8_pkg::PRE_W) begin : g_param_chk
        $error("pcler8_seq_ctrl: CNT_W must be 8 and PRE_W must match pcler8_pkg::PRE_W");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    cfg_t             r_cfg;
    logic [7:0]       r_cnt;
    logic [PRE_W-1:0] r_pre;
    logic             r_tc;

    logic             w_rdy;
    logic             w_run;
    logic             w_accept;
    logic             w_pre_hit;
    logic             w_step;
    logic             w_load;
    logic             w_inhibit;
    logic [7:0]       w_next_cnt;
    logic             w_carry;

    assign w_rdy     = (r_state == IDLE) || (r_state == DONE);
    assign w_run     = (r_state == RUN);
    // Abort in DONE beats a simultaneous config; in IDLE abort is a no-op.
    assign w_accept  = bus.cfg_valid & w_rdy & ~(bus.abort & (r_state == DONE));
    assign w_pre_hit = (r_pre == r_cfg.prescale);
    // Abort discards a step landing in the same cycle, so no wrap or pulse.
    assign w_step    = w_run & bus.run_en & w_pre_hit & ~bus.abort;
    assign w_load    = (r_state == LOAD) & ~bus.abort;
    assign w_inhibit = ~w_run | ~bus.run_en;

    pcler8_next u_next (
        .i_cnt      (r_cnt),
        .i_din      (r_cfg.start),
        .i_reload   (r_cfg.reload),
        .i_load     (w_load),
        .i_cnt_en   (w_step),
        .i_inhibit  (w_inhibit),
        .o_next_cnt (w_next_cnt),
        .o_carry    (w_carry)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = LOAD;
            LOAD: w_state_nxt = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort)                  w_state_nxt = IDLE;
                else if (w_carry && !r_cfg.mode) w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.abort)     w_state_nxt = IDLE;
                else if (w_accept) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_next_cnt;
            r_tc    <= w_carry;
            if (w_accept) begin
                r_cfg <= '{start:    bus.cfg_start,
                           reload:   bus.cfg_reload,
                           mode:     bus.cfg_mode,
                           prescale: bus.cfg_prescale};
            end
            // Prescaler phase restarts with each load and survives pauses.
            if (w_load) begin
                r_pre <= '0;
            end else if (w_run && bus.run_en && !bus.abort) begin
                r_pre <= w_pre_hit ? '0 : r_pre + PRE_W'(1);
            end
        end
    end

    assign bus.cfg_ready = w_rdy;
    assign bus.cnt_out   = r_cnt;
    assign bus.tc_pulse  = r_tc;
    assign bus.busy      = (r_state == LOAD) || (r_state == RUN);
    assign bus.done      = (r_state == DONE);
endmodule
